// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding and default width for the
//               shift-and-add multiplier controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rca_adder.sv
// ============================================================================
// Module      : rca_adder (with full_adder cell)
// Description : WIDTH-bit combinational ripple-carry adder chained from
//               single-bit full-adder cells.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_carry[i]),
            .sum  (sum[i]),
            .cout (w_carry[i+1])
        );
    end

    assign cout = w_carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
// ============================================================================
// Module      : shift_add_mult_ctrl
// Description : Sequential shift-and-add unsigned multiplier, one adder pass
//               per cycle, start/done handshake. Optional macro
//               MULT_ZERO_BYPASS_EN skips RUN when either operand is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH   // must be >= 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int            CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_co;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;
    logic             w_zero_op;

    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    rca_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (r_acc_hi),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_co)
    );

    // {co, sum, acc_lo} shifted right by one; the adder carry becomes the new MSB
    assign w_next_hi = {w_co, w_sum[WIDTH-1:1]};
    assign w_next_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};

`ifdef MULT_ZERO_BYPASS_EN
    assign w_zero_op = (A == '0) || (B == '0);
`else
    assign w_zero_op = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_count  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            P        <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= A;
                        r_acc_lo <= B;
                        r_acc_hi <= '0;
                        r_count  <= '0;
                        busy     <= 1'b1;
                        if (w_zero_op) begin
                            P       <= '0;
                            done    <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_acc_hi <= w_next_hi;
                    r_acc_lo <= w_next_lo;
                    r_count  <= r_count + C_ONE;
                    if (r_count == C_LAST) begin
                        P       <= {w_next_hi, w_next_lo};
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
// ============================================================================
// Module      : tb_shift_add_mult_ctrl
// Description : Self-checking bench for shift_add_mult_ctrl: vector table,
//               handshake corner sequences and random operands vs a*b.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_mult_ctrl;

    localparam int W = 4;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] P;

    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] last_p;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycles from the accepting edge until done is high
    function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        if (BYPASS && (a == '0 || b == '0)) return 0;
        return W;
    endfunction

    // One full transaction from IDLE; optionally pulses start with new operands mid-run
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] expp, input bit pulse);
        int lat;
        lat = exp_latency(a, b);
        @(negedge clk);
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check("busy_in_op", busy, 1'b1);
            check("done_pulse", done, (k == lat));
            check("p_value", P, (k >= lat) ? expp : last_p);
            if (pulse && k == 1) begin
                start = 1'b1;
                A     = 4'd7;
                B     = 4'd2;
            end
            if (pulse && k == 2) start = 1'b0;
        end
        @(negedge clk);
        check("busy_after", busy, 1'b0);
        check("done_after", done, 1'b0);
        check("p_hold", P, expp);
        last_p = expp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic [2*W-1:0] rp;

        tbl[0] = '{a: 4'd3,  b: 4'd5,  p: 8'd15};
        tbl[1] = '{a: 4'd15, b: 4'd15, p: 8'd225};
        tbl[2] = '{a: 4'd9,  b: 4'd1,  p: 8'd9};
        tbl[3] = '{a: 4'd0,  b: 4'd9,  p: 8'd0};
        tbl[4] = '{a: 4'd6,  b: 4'd0,  p: 8'd0};
        tbl[5] = '{a: 4'd15, b: 4'd1,  p: 8'd15};
        tbl[6] = '{a: 4'd12, b: 4'd11, p: 8'd132};

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #2;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_p", P, 8'd0);
        @(negedge clk);
        rst    = 1'b0;
        last_p = '0;

        for (int i = 0; i < 7; i++) begin
            run_mult(tbl[i].a, tbl[i].b, tbl[i].p, 1'b0);
        end

        // start pulsed during RUN with different operands must be ignored
        run_mult(4'd11, 4'd13, 8'd143, 1'b1);

        // start held high: one result every W+2 cycles
        @(negedge clk);
        start = 1'b1;
        A     = 4'd2;
        B     = 4'd6;
        for (int c = 0; c < 18; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("held_done", done, ((c % 6) == 4));
            check("held_busy", busy, ((c % 6) != 5));
            check("held_p", P, (c >= 4) ? 8'd12 : last_p);
            if (c == 16) start = 1'b0;
        end
        last_p = 8'd12;
        @(negedge clk);
        check("held_idle", busy, 1'b0);

        // asynchronous reset two cycles into RUN aborts the operation
        @(negedge clk);
        start = 1'b1;
        A     = 4'd5;
        B     = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_p", P, 8'd0);
        @(negedge clk);
        rst    = 1'b0;
        last_p = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
            check("abort_idle", busy, 1'b0);
        end
        run_mult(4'd5, 4'd5, 8'd25, 1'b0);

        // random operands against the arithmetic reference
        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rp = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            run_mult(ra, rb, rp, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
